// File: rtl/seg7_scan_pkg.sv
// Shared constants, state type and helpers for the multiplexed 4-digit
// seven-segment scan driver.
package seg7_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;
  localparam int DP_DIGIT   = 2;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int BUS_W      = NUM_DIGITS * SEG_W;

  localparam logic [SEG_W-1:0]      SEG_OFF = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'b1111;

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_t;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [NUM_DIGITS-1:0] an_select(input logic [DIGIT_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the stopwatch display latch (master) and the scan driver
// (slave): parallel segment patterns and controls in, display pins out.
interface seg7_scan_driver_if;
  import seg7_scan_pkg::*;

  logic [BUS_W-1:0]      seg_bus;
  logic                  FLASH;
  logic                  DP_EN;
  logic [NUM_DIGITS-1:0] AN;
  logic [SEG_W-1:0]      SEG;
  logic                  DP;
  logic                  frame_done;

  modport master (
    output seg_bus, FLASH, DP_EN,
    input  AN, SEG, DP, frame_done
  );

  modport slave (
    input  seg_bus, FLASH, DP_EN,
    output AN, SEG, DP, frame_done
  );

endinterface

// File: rtl/seg7_slot_timer.sv
// Digit-slot prescaler: counts clk_in cycles within a slot, steps the digit
// index on every slot wrap and flags the last cycle of a slot and of a frame.
module seg7_slot_timer
  import seg7_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  localparam int CNT_W      = $clog2(REFRESH_DIV)
) (
  input  logic               clk_in,
  input  logic               RESET,
  output logic [CNT_W-1:0]   slot_cnt,
  output logic [DIGIT_W-1:0] digit_idx,
  output logic               slot_end,
  output logic               frame_end
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [DIGIT_W-1:0] digit_idx_q, digit_idx_d;

  always_comb begin
    slot_end    = (slot_cnt_q == CNT_MAX);
    frame_end   = slot_end && (digit_idx_q == DIGIT_MAX);
    slot_cnt_d  = slot_end ? '0 : slot_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_end) begin
      digit_idx_d = (digit_idx_q == DIGIT_MAX) ? '0 : digit_idx_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge RESET) begin
    if (RESET) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign slot_cnt  = slot_cnt_q;
  assign digit_idx = digit_idx_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode driver: frame-synchronous snapshot of the
// segment bus, per-slot blanking, whole-display blink and separator dot.
module seg7_scan_driver
  import seg7_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk_in,
  input  logic               RESET,
  seg7_scan_driver_if.slave  bus
);

  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam int BLINK_W = $clog2(2 * BLINK_FRAMES);

  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(2 * BLINK_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_ON   = BLINK_W'(BLINK_FRAMES);
  // With no blank phase the slot starts straight in DRIVE.
  localparam scan_state_t RESET_STATE = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  logic [CNT_W-1:0]   slot_cnt;
  logic [DIGIT_W-1:0] digit_idx;
  logic               slot_end;
  logic               frame_end;

  seg7_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_slot_timer (
    .clk_in    (clk_in),
    .RESET     (RESET),
    .slot_cnt  (slot_cnt),
    .digit_idx (digit_idx),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  scan_state_t           state_q, state_d;
  logic [BUS_W-1:0]      shadow_q, shadow_d;
  logic [BLINK_W-1:0]    blink_q, blink_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;
  logic                  dark;

  always_comb begin
    // state_q tracks the phase of the current slot counter value.
    state_d = state_q;
    case (state_q)
      BLANK: if (slot_cnt == BLANK_LAST) state_d = DRIVE;
      DRIVE: if (slot_end && (BLANK_CYCLES != 0)) state_d = BLANK;
    endcase

    dark = (state_q == BLANK) || (bus.FLASH && (blink_q >= BLINK_ON));
    an_d = AN_OFF;
    seg_d = SEG_OFF;
    dp_d = 1'b1;
    if (!dark) begin
      an_d  = an_select(digit_idx);
      seg_d = ~shadow_q[digit_idx*SEG_W +: SEG_W];
      dp_d  = ~(bus.DP_EN && (digit_idx == DIGIT_W'(DP_DIGIT)));
    end

    // Snapshot and blink step share the frame boundary; the display keeps
    // using the old values until the following cycle.
    shadow_d     = frame_end ? bus.seg_bus : shadow_q;
    frame_done_d = frame_end;
    blink_d      = blink_q;
    if (frame_end) begin
      blink_d = (blink_q == BLINK_MAX) ? '0 : blink_q + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge RESET) begin
    if (RESET) begin
      state_q      <= BLANK;
      shadow_q     <= '0;
      blink_q      <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
      if (RESET_STATE == DRIVE) state_q <= DRIVE;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      blink_q      <= blink_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;
  assign bus.DP         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver: two instances (with and without a
// blank phase) compared every cycle against an arithmetic timing model.
module tb_seg7_scan_driver;
  import seg7_scan_pkg::*;

  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;
  localparam logic [12:0] RESET_EXP = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic clk_in = 1'b0;
  logic RESET;
  always #5 clk_in = ~clk_in;

  logic [27:0] seg_bus_tb;
  logic        flash_tb;
  logic        dp_en_tb;

  seg7_scan_driver_if bus_b ();
  seg7_scan_driver_if bus_n ();

  assign bus_b.seg_bus = seg_bus_tb;
  assign bus_b.FLASH   = flash_tb;
  assign bus_b.DP_EN   = dp_en_tb;
  assign bus_n.seg_bus = seg_bus_tb;
  assign bus_n.FLASH   = flash_tb;
  assign bus_n.DP_EN   = dp_en_tb;

  seg7_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK),
    .BLINK_FRAMES (BF)
  ) dut_b (
    .clk_in (clk_in),
    .RESET  (RESET),
    .bus    (bus_b.slave)
  );

  seg7_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (0),
    .BLINK_FRAMES (BF)
  ) dut_n (
    .clk_in (clk_in),
    .RESET  (RESET),
    .bus    (bus_n.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  int          k;
  logic [27:0] model_shadow;
  logic [12:0] exp_b, exp_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // Expected pins {AN, SEG, DP, frame_done} after the clock edge that sees
  // step kk (cycles since reset release), from slot/frame arithmetic.
  function automatic logic [12:0] predict(input int kk, input int blank,
                                          input logic [27:0] shadow,
                                          input logic fl, input logic de);
    int         cnt, idx, frm, blink;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, fd;
    cnt   = kk % DIV;
    idx   = (kk / DIV) % 4;
    frm   = kk / FRAME;
    blink = frm % (2 * BF);
    an    = 4'hF;
    seg   = 7'h7F;
    dp    = 1'b1;
    fd    = (cnt == DIV - 1) && (idx == 3);
    if (!(cnt < blank) && !(fl && blink >= BF)) begin
      an  = ~(4'b0001 << idx);
      seg = ~shadow[7*idx +: 7];
      dp  = !(de && idx == 2);
    end
    return {an, seg, dp, fd};
  endfunction

  task automatic compare_outputs();
    check("blank_AN",  32'(bus_b.AN),         32'(exp_b[12:9]));
    check("blank_SEG", 32'(bus_b.SEG),        32'(exp_b[8:2]));
    check("blank_DP",  32'(bus_b.DP),         32'(exp_b[1]));
    check("blank_FD",  32'(bus_b.frame_done), 32'(exp_b[0]));
    check("noblk_AN",  32'(bus_n.AN),         32'(exp_n[12:9]));
    check("noblk_SEG", 32'(bus_n.SEG),        32'(exp_n[8:2]));
    check("noblk_DP",  32'(bus_n.DP),         32'(exp_n[1]));
    check("noblk_FD",  32'(bus_n.frame_done), 32'(exp_n[0]));
  endtask

  task automatic apply(input logic [27:0] sb, input logic fl, input logic de);
    seg_bus_tb = sb;
    flash_tb   = fl;
    dp_en_tb   = de;
    exp_b = predict(k, BLK, model_shadow, fl, de);
    exp_n = predict(k, 0, model_shadow, fl, de);
    if ((k % DIV == DIV - 1) && ((k / DIV) % 4 == 3)) model_shadow = sb;
    k++;
  endtask

  task automatic run_cycle(input logic [27:0] sb, input logic fl, input logic de);
    @(negedge clk_in);
    compare_outputs();
    apply(sb, fl, de);
  endtask

  task automatic release_reset(input logic [27:0] sb);
    @(negedge clk_in);
    compare_outputs();
    RESET        = 1'b0;
    k            = 0;
    model_shadow = '0;
    apply(sb, 1'b0, 1'b0);
  endtask

  task automatic run_random(input int frames);
    logic [27:0] sb;
    logic        fl, de;
    sb = seg_bus_tb;
    fl = flash_tb;
    de = dp_en_tb;
    for (int i = 0; i < frames * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) sb = 28'($urandom);
      if ($urandom_range(0, 23) == 0) fl = ~fl;
      if ($urandom_range(0, 7) == 0)  de = ~de;
      run_cycle(sb, fl, de);
    end
  endtask

  logic [27:0] pat_1234;
  logic [27:0] pat_all;

  initial begin
    pat_1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    pat_all  = {4{7'h7F}};
    RESET      = 1'b1;
    seg_bus_tb = '0;
    flash_tb   = 1'b0;
    dp_en_tb   = 1'b0;
    k          = 0;
    model_shadow = '0;
    exp_b = RESET_EXP;
    exp_n = RESET_EXP;

    $display("txn reset: hold reset, expect all pins off");
    repeat (2) begin
      @(negedge clk_in);
      compare_outputs();
    end
    release_reset('0);

    $display("txn first_frame: blank shadow, digits scanned dark");
    repeat (FRAME - 1) run_cycle('0, 1'b0, 1'b0);

    $display("txn pattern_1234: held for two frames");
    repeat (2 * FRAME) run_cycle(pat_1234, 1'b0, 1'b0);

    $display("txn midframe_change: bus goes all-on at digit 1");
    repeat (DIV) run_cycle(pat_1234, 1'b0, 1'b0);
    repeat (FRAME + 3 * DIV) run_cycle(pat_all, 1'b0, 1'b0);

    $display("txn dp_enable: separator dot on digit 2");
    repeat (FRAME) run_cycle(pat_1234, 1'b0, 1'b1);

    $display("txn flash: eight frames then release in a dark frame");
    repeat (8 * FRAME + 2 * DIV + 3) run_cycle(pat_1234, 1'b1, 1'b0);
    repeat (FRAME) run_cycle(pat_1234, 1'b0, 1'b0);

    $display("txn random: 20 frames of random bus, flash and dot");
    run_random(20);

    $display("txn async_reset: reset asserted mid-slot");
    for (int i = 0; i < DIV && (k % DIV) != 5; i++) run_cycle(pat_1234, 1'b0, 1'b0);
    @(posedge clk_in);
    #2;
    compare_outputs();
    RESET = 1'b1;
    #1;
    exp_b = RESET_EXP;
    exp_n = RESET_EXP;
    compare_outputs();
    release_reset(pat_1234);

    $display("txn after_reset: blank first frame then random");
    repeat (FRAME - 1) run_cycle(pat_1234, 1'b0, 1'b0);
    run_random(4);
    @(negedge clk_in);
    compare_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the stopwatch's parallel 4-digit seven-segment bus (28 bits, active-high segments) and drives a time-multiplexed common-anode 4-digit display.
- Outputs are active-low anode selects and active-low cathodes.
- Sits between the stopwatch display latch and the board pins.
- Adds frame-synchronous capture (no tearing), inter-digit blanking (anti-ghosting), whole-display blink, and a minutes/seconds separator dot.

Parameters:
- REFRESH_DIV, 50000: clk_in cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; legal range 0 to REFRESH_DIV-1; 0 means no blank phase.
- BLINK_FRAMES, 64: frames per blink half-period; must be ≥ 1.

Ports:
- clk_in  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- seg_bus  input  28  segment patterns, active-high. Digit d occupies [7d+6:7d]; bit 0 = a … bit 6 = g. Digit 0 = seconds ones, digit 3 = minutes tens.
- FLASH  input  1  1 = blink whole display.
- DP_EN  input  1  1 = light the decimal point on digit 2.
- AN  output  4  anode selects, active-low, one-hot-low while driving.
- SEG  output  7  cathodes, active-low, same bit order as seg_bus.
- DP  output  1  decimal-point cathode, active-low.
- frame_done  output  1  one-cycle pulse at the end of the digit-3 slot.

Behaviour:
- Reset values (asynchronous): AN=4'b1111, SEG=7'b1111111, DP=1, frame_done=0, slot counter=0, digit_idx=0, FSM=BLANK, shadow=28'h0, blink counter=0.
- Slot counter: counts 0..REFRESH_DIV-1 and wraps. digit_idx increments on each wrap, 3→0.
- FSM has two states:
  - BLANK: holds while slot counter < BLANK_CYCLES. AN=1111, SEG=1111111, DP=1.
  - DRIVE: for the rest of the slot. AN[digit_idx]=0 (others 1). SEG = ~shadow[7*digit_idx +: 7]. DP = ~(DP_EN & digit_idx==2).
- With BLANK_CYCLES=0 the FSM never enters BLANK; DRIVE lasts the whole slot.
- Outputs are registered. The pins reflect state/counter one cycle after the counter value that selects them.
- Capture: shadow <= seg_bus in the cycle where slot counter==REFRESH_DIV-1 and digit_idx==3, i.e. on the frame boundary. The whole frame therefore shows one coherent snapshot. seg_bus changes mid-frame are invisible until the next frame.
- frame_done: 1 in that same capture cycle (registered, so visible the next cycle, aligned with digit 0's first slot cycle).
- Blink counter: increments each frame_done, modulo 2*BLINK_FRAMES, free-running regardless of FLASH.
  - When FLASH=1 and blink counter ≥ BLINK_FRAMES, DRIVE forces AN=1111, SEG=1111111, DP=1. Timing is unchanged.
  - FLASH deassertion takes effect on the next cycle with no wait.
- Simultaneous events:
  - Capture and blink-count update happen in the same cycle; the blink decision uses the updated count from the next cycle.
  - DP_EN and FLASH are sampled every cycle (not frame-synchronous).
- Reset mid-frame: all state returns to reset values immediately. The first frame after reset displays a blank shadow (all segments off), and the first capture occurs at the end of that frame.
- Width rules:
  - Slot counter width is $clog2(REFRESH_DIV).
  - Blink counter width is $clog2(2*BLINK_FRAMES).
  - No arithmetic overflow is permitted; wraps are explicit compares.

Decomposition:
- Package seg7_scan_pkg:
  - NUM_DIGITS=4, SEG_W=7, DP_DIGIT=2.
  - Typedef scan_state_t {BLANK, DRIVE}.
  - Constant SEG_OFF=7'b1111111.
- One sub-module, seg7_slot_timer: parameterised prescaler producing slot counter, digit_idx, and the end-of-slot/end-of-frame strobes.
- The FSM, capture, blink logic and output registers live in the top module.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2 unless stated):
- Reset, seg_bus=28'h0 → AN=1111, SEG=7F, DP=1, frame_done=0. During the first frame, every DRIVE cycle shows AN one-hot-low and SEG=7F.
- seg_bus pattern "12:34" (digit3=7'h06, digit2=7'h5B, digit1=7'h4F, digit0=7'h66) held for 2 frames → in frame 2, slot d shows AN with bit d low for 6 cycles, preceded by 2 cycles of AN=1111. SEG sequence is 0x19, 0x30, 0x24, 0x79 for d=0..3. frame_done pulses once every 32 cycles.
- Change seg_bus to all 7'h7F mid-frame at digit 1 → digits 1–3 of the current frame still show the old values. The next frame shows SEG=0x00 on all digits.
- DP_EN=1 → DP=0 only during digit-2 DRIVE cycles; DP=1 during BLANK and the other digits.
- FLASH=1 for 8 frames → frames alternate 2 lit, 2 dark (AN=1111 throughout the dark frames). Deasserting FLASH during a dark frame lights the next DRIVE cycle.
- BLANK_CYCLES=0 → AN is never 1111 once digits are driven, and each digit is driven for 8 consecutive cycles. Asserting RESET mid-slot forces AN=1111 within the same cycle (asynchronous).
